// File: rtl/alu_seq_core.sv
// alu_seq_core
//   Button-sequenced operand loader and ALU. Operand A is loaded on one
//   execute press. The next press loads B, latches op and launches the
//   operation. MUL (shift-add) and DIV (restoring) take WIDTH cycles; all
//   other ops complete in one RUN cycle.
// Ports
//   clk, reset      clock; asynchronous active-low reset
//   btn_exec, clr   asynchronous button levels, synchronised internally
//   op, din         operation select and operand input
//   a_q, b_q        operand registers
//   y, y_hi         result low half; MUL high half / DIV remainder
//   carry, zero, ovf, err  status flags
//   busy, done      RUN indicator; one-cycle completion pulse
//   state_o         0=LOAD_A 1=LOAD_B 2=RUN 3=DONE
module alu_seq_core #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_exec,
  input  logic             clr,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             err,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] exec_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                 exec_prev;
  logic                 press;
  logic                 clr_s;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     work_hi;
  logic [WIDTH-1:0]     work_lo;
  logic [CW-1:0]        cnt;

  logic [WIDTH:0]       sum_ext;
  logic [WIDTH:0]       diff_ext;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     mul_hi_nxt;
  logic [WIDTH-1:0]     mul_lo_nxt;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_sub;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem_nxt;
  logic [WIDTH-1:0]     div_quo_nxt;
  logic                 is_multi;
  logic                 last;

  logic [WIDTH-1:0]     r_y;
  logic [WIDTH-1:0]     r_hi;
  logic                 r_c;
  logic                 r_v;
  logic                 r_e;

  assign clr_s   = clr_sync[SYNC_STAGES-1];
  assign press   = exec_sync[SYNC_STAGES-1] & ~exec_prev;
  assign busy    = (state == RUN);
  assign state_o = state;

  // MUL: work_hi:work_lo holds the partial product, multiplier shifts out of work_lo.
  // DIV: work_hi holds the partial remainder, dividend shifts out of work_lo as the
  // quotient shifts in.
  always_comb begin
    mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : '0);
    mul_hi_nxt  = mul_sum[WIDTH:1];
    mul_lo_nxt  = {mul_sum[0], work_lo[WIDTH-1:1]};
    div_shift   = {work_hi, work_lo[WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, b_q});
    div_sub     = div_shift - {1'b0, b_q};
    div_rem_nxt = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_nxt = {work_lo[WIDTH-2:0], div_ge};
    is_multi    = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
    last        = !is_multi || (cnt == '0);
  end

  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    r_y  = '0;
    r_hi = '0;
    r_c  = 1'b0;
    r_v  = 1'b0;
    r_e  = 1'b0;
    case (op_q)
      OP_ADD: begin
        r_y = sum_ext[WIDTH-1:0];
        r_c = sum_ext[WIDTH];
        r_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        r_y = diff_ext[WIDTH-1:0];
        r_c = diff_ext[WIDTH];
        r_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: r_y = a_q & b_q;
      OP_OR:  r_y = a_q | b_q;
      OP_XOR: r_y = a_q ^ b_q;
      OP_NOT: r_y = ~a_q;
      OP_SHL: begin
        r_y = {a_q[WIDTH-2:0], 1'b0};
        r_c = a_q[WIDTH-1];
      end
      OP_SHR: begin
        r_y = {1'b0, a_q[WIDTH-1:1]};
        r_c = a_q[0];
      end
      OP_MUL: begin
        r_y  = mul_lo_nxt;
        r_hi = mul_hi_nxt;
        r_v  = (mul_hi_nxt != '0);
      end
      OP_DIV: begin
        if (b_q == '0) begin
          r_y  = '1;
          r_hi = a_q;
          r_e  = 1'b1;
        end else begin
          r_y  = div_quo_nxt;
          r_hi = div_rem_nxt;
        end
      end
      default: r_e = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_sync <= '0;
      clr_sync  <= '0;
      exec_prev <= 1'b0;
    end else begin
      exec_sync <= {exec_sync[SYNC_STAGES-2:0], btn_exec};
      clr_sync  <= {clr_sync[SYNC_STAGES-2:0], clr};
      exec_prev <= exec_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      y       <= '0;
      y_hi    <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
      op_q    <= '0;
      work_hi <= '0;
      work_lo <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (clr_s) begin
        state   <= LOAD_A;
        a_q     <= '0;
        b_q     <= '0;
        y       <= '0;
        y_hi    <= '0;
        carry   <= 1'b0;
        zero    <= 1'b0;
        ovf     <= 1'b0;
        err     <= 1'b0;
        work_hi <= '0;
        work_lo <= '0;
        cnt     <= '0;
      end else begin
        case (state)
          LOAD_A: begin
            if (press) begin
              a_q   <= din;
              state <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (press) begin
              b_q     <= din;
              op_q    <= op;
              work_hi <= '0;
              work_lo <= (op == OP_MUL) ? din : a_q;
              cnt     <= CW'(WIDTH - 1);
              state   <= RUN;
            end
          end
          RUN: begin
            if (is_multi) begin
              work_hi <= (op_q == OP_MUL) ? mul_hi_nxt : div_rem_nxt;
              work_lo <= (op_q == OP_MUL) ? mul_lo_nxt : div_quo_nxt;
              if (cnt != '0) cnt <= cnt - CW'(1);
            end
            if (last) begin
              y     <= r_y;
              y_hi  <= r_hi;
              carry <= r_c;
              ovf   <= r_v;
              err   <= r_e;
              zero  <= (r_y == '0);
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            if (press) begin
              a_q   <= din;
              state <= LOAD_B;
            end
          end
          default: state <= LOAD_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: an 8-bit and a 16-bit instance,
// directed scenarios followed by randomized operations compared against an
// arithmetic reference model.
module tb_alu_seq_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn8, btn16, clr8, clr16;
  logic [3:0]  op_r;
  logic [15:0] din_r;
  logic        sel;

  logic [7:0]  a8, b8, y8, yh8;
  logic        c8, z8, v8, e8, bz8, d8;
  logic [1:0]  st8;
  logic [15:0] a16, b16, y16, yh16;
  logic        c16, z16, v16, e16, bz16, d16;
  logic [1:0]  st16;

  logic [15:0] a_v, b_v, y_v, yh_v;
  logic        c_v, z_v, v_v, e_v, bz_v, d_v;
  logic [1:0]  st_v;

  int unsigned n_pass;
  int unsigned n_total;

  typedef struct {
    logic [31:0] y;
    logic [31:0] yh;
    logic        c;
    logic        v;
    logic        e;
    logic        z;
    int unsigned lat;
  } res_t;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .btn_exec(btn8), .clr(clr8), .op(op_r),
    .din(din_r[7:0]), .a_q(a8), .b_q(b8), .y(y8), .y_hi(yh8),
    .carry(c8), .zero(z8), .ovf(v8), .err(e8), .busy(bz8), .done(d8),
    .state_o(st8)
  );

  alu_seq_core #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .btn_exec(btn16), .clr(clr16), .op(op_r),
    .din(din_r), .a_q(a16), .b_q(b16), .y(y16), .y_hi(yh16),
    .carry(c16), .zero(z16), .ovf(v16), .err(e16), .busy(bz16), .done(d16),
    .state_o(st16)
  );

  always_comb begin
    if (sel) begin
      a_v = a16; b_v = b16; y_v = y16; yh_v = yh16;
      c_v = c16; z_v = z16; v_v = v16; e_v = e16; bz_v = bz16; d_v = d16;
      st_v = st16;
    end else begin
      a_v = {8'h00, a8}; b_v = {8'h00, b8}; y_v = {8'h00, y8}; yh_v = {8'h00, yh8};
      c_v = c8; z_v = z8; v_v = v8; e_v = e8; bz_v = bz8; d_v = d8;
      st_v = st8;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic res_t model(input int unsigned w, input longint unsigned a,
                                 input longint unsigned b, input int unsigned opc);
    res_t r;
    longint unsigned m, p;
    longint full, half, sa, sb, sr;
    m    = (64'd1 << w) - 64'd1;
    full = longint'(64'd1 << w);
    half = longint'(64'd1 << (w - 1));
    sa   = (longint'(a) >= half) ? longint'(a) - full : longint'(a);
    sb   = (longint'(b) >= half) ? longint'(b) - full : longint'(b);
    r.y = '0; r.yh = '0; r.c = 1'b0; r.v = 1'b0; r.e = 1'b0; r.lat = 1;
    case (opc)
      0: begin
        r.y = 32'((a + b) & m);
        r.c = ((a + b) >> w) != 0;
        sr  = sa + sb;
        r.v = (sr >= half) || (sr < -half);
      end
      1: begin
        r.y = 32'((a - b) & m);
        r.c = a < b;
        sr  = sa - sb;
        r.v = (sr >= half) || (sr < -half);
      end
      2: r.y = 32'(a & b);
      3: r.y = 32'(a | b);
      4: r.y = 32'(a ^ b);
      5: r.y = 32'(~a & m);
      6: begin r.y = 32'((a << 1) & m); r.c = ((a >> (w - 1)) & 64'd1) != 0; end
      7: begin r.y = 32'(a >> 1); r.c = (a & 64'd1) != 0; end
      8: begin
        p     = a * b;
        r.y   = 32'(p & m);
        r.yh  = 32'(p >> w);
        r.v   = (p >> w) != 0;
        r.lat = w;
      end
      9: begin
        if (b == 0) begin
          r.y = 32'(m); r.yh = 32'(a); r.e = 1'b1;
        end else begin
          r.y = 32'(a / b); r.yh = 32'(a % b); r.lat = w;
        end
      end
      default: r.e = 1'b1;
    endcase
    r.z = (r.y == 0);
    return r;
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic v);
    if (sel) btn16 = v; else btn8 = v;
  endtask

  task automatic press_a(input logic [15:0] a);
    din_r = a;
    set_btn(1'b1);
    tick(4);
    set_btn(1'b0);
    tick(4);
  endtask

  task automatic run_op(input logic s, input int unsigned w, input logic [15:0] a_in,
                        input logic [15:0] b_in, input logic [3:0] opc, input string tag);
    res_t        r;
    int unsigned nb, nd;
    logic [15:0] a, b;
    a = (w == 8) ? {8'h00, a_in[7:0]} : a_in;
    b = (w == 8) ? {8'h00, b_in[7:0]} : b_in;
    sel = s;
    press_a(a);
    chk({tag, "_a_q"}, 32'(a_v), 32'(a));
    chk({tag, "_st_loadb"}, 32'(st_v), 32'd1);
    din_r = b;
    op_r  = opc;
    set_btn(1'b1);
    nb = 0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 3) op_r = 4'($urandom);
      if (bz_v) nb++;
      if (d_v) nd++;
    end
    set_btn(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_v) nd++;
    end
    r = model(w, longint'(a), longint'(b), 32'(opc));
    chk({tag, "_b_q"}, 32'(b_v), 32'(b));
    chk({tag, "_y"}, 32'(y_v), r.y);
    chk({tag, "_y_hi"}, 32'(yh_v), r.yh);
    chk({tag, "_carry"}, 32'(c_v), 32'(r.c));
    chk({tag, "_zero"}, 32'(z_v), 32'(r.z));
    chk({tag, "_ovf"}, 32'(v_v), 32'(r.v));
    chk({tag, "_err"}, 32'(e_v), 32'(r.e));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(r.lat));
    chk({tag, "_done_pulses"}, 32'(nd), 32'd1);
    chk({tag, "_st_done"}, 32'(st_v), 32'd3);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_q"}, 32'(a_v), 32'd0);
    chk({tag, "_b_q"}, 32'(b_v), 32'd0);
    chk({tag, "_y"}, 32'(y_v), 32'd0);
    chk({tag, "_y_hi"}, 32'(yh_v), 32'd0);
    chk({tag, "_flags"}, 32'({c_v, z_v, v_v, e_v, bz_v, d_v}), 32'd0);
    chk({tag, "_state"}, 32'(st_v), 32'd0);
  endtask

  initial begin
    int unsigned nd, nb;
    logic        seen;
    logic        s;
    int unsigned w;
    logic [15:0] ra, rb;
    logic [3:0]  ro;

    n_pass  = 0;
    n_total = 0;
    sel     = 1'b0;
    reset   = 1'b0;
    btn8 = 1'b0; btn16 = 1'b0; clr8 = 1'b0; clr16 = 1'b0;
    op_r  = '0;
    din_r = '0;
    tick(3);
    check_all_zero("rst");
    reset = 1'b1;
    tick(2);

    // Reset asserted mid-MUL, then released.
    press_a(16'h0033);
    din_r = 16'h0044; op_r = 4'd8; btn8 = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    check_all_zero("rst_mid");
    btn8  = 1'b0;
    reset = 1'b1;
    tick(3);
    chk("rst_rel_state", 32'(st_v), 32'd0);
    press_a(16'h003C);
    chk("rst_first_a", 32'(a_v), 32'h3C);
    chk("rst_first_state", 32'(st_v), 32'd1);
    clr8 = 1'b1; tick(4); clr8 = 1'b0; tick(4);
    check_all_zero("clr_loadb");

    // Directed cases.
    run_op(1'b0, 8, 16'h007F, 16'h0001, 4'd0, "add_ovf");
    chk("add_ovf_y_lit", 32'(y_v), 32'h80);
    run_op(1'b0, 8, 16'h0010, 16'h0020, 4'd8, "mul");
    chk("mul_yhi_lit", 32'(yh_v), 32'h02);
    run_op(1'b0, 8, 16'd200, 16'd7, 4'd9, "div");
    chk("div_y_lit", 32'(y_v), 32'h1C);
    run_op(1'b0, 8, 16'h0055, 16'h0000, 4'd9, "div0");
    run_op(1'b0, 8, 16'h0005, 16'h0009, 4'd1, "sub_borrow");
    chk("sub_y_lit", 32'(y_v), 32'hFC);
    run_op(1'b1, 16, 16'hFFFF, 16'h0001, 4'd0, "add16_wrap");
    chk("add16_zero_lit", 32'(z_v), 32'd1);
    run_op(1'b0, 8, 16'h0033, 16'h0044, 4'd12, "illegal");
    run_op(1'b0, 8, 16'h0081, 16'h0000, 4'd6, "shl");
    run_op(1'b0, 8, 16'h0081, 16'h0000, 4'd7, "shr");

    // clr three cycles into MUL.
    sel = 1'b0;
    press_a(16'h0010);
    din_r = 16'h0020; op_r = 4'd8; btn8 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bz_v) begin seen = 1'b1; break; end
    end
    chk("clr_mul_started", 32'(seen), 32'd1);
    tick(3);
    clr8 = 1'b1;
    nd = 0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_v) nd++;
      if (i == 10 && bz_v) nb++;
    end
    btn8 = 1'b0;
    tick(2);
    clr8 = 1'b0;
    tick(4);
    chk("clr_mul_no_done", 32'(nd), 32'd0);
    chk("clr_mul_not_busy", 32'(nb), 32'd0);
    check_all_zero("clr_mul");

    // clr and press together.
    run_op(1'b0, 8, 16'h00F0, 16'h000F, 4'd3, "pre_clr");
    nd = 0;
    btn8 = 1'b1; clr8 = 1'b1; din_r = 16'h005A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d_v) nd++;
    end
    btn8 = 1'b0;
    tick(2);
    clr8 = 1'b0;
    tick(4);
    chk("clr_press_no_done", 32'(nd), 32'd0);
    check_all_zero("clr_press");

    // Randomized operations on both widths.
    for (int i = 0; i < 32; i++) begin
      s  = (i % 4) == 3;
      w  = s ? 16 : 8;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      ro = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(8, 9)) : 4'($urandom_range(0, 15));
      run_op(s, w, ra, rb, ro, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
